// File: rtl/pes_elevator_pkg.sv
// Shared types and helpers for the pes_elevator request scheduler.
package pes_elevator_pkg;
  localparam int DEF_NUM_FLOORS  = 8;
  localparam int DEF_DOOR_CYCLES = 4;
  localparam int MAX_FLOORS      = 32;

  typedef enum logic [1:0] {IDLE, SELECT, DISPATCH, DOOR} state_e;

  function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
    return $onehot(v);
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic int onehot_to_index(input logic [MAX_FLOORS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (v[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/pes_scan_select.sv
// SCAN priority search: serve here, else nearest in travel direction, else nearest behind.
module pes_scan_select import pes_elevator_pkg::*; #(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int IW         = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [IW-1:0]         cur_idx,
  input  logic                  dir_up,
  output logic                  hit_here,
  output logic [IW-1:0]         next_index,
  output logic                  next_valid,
  output logic                  next_dir
);
  logic          has_up, has_dn;
  logic [IW-1:0] up_idx, dn_idx;

  always_comb begin
    has_up = 1'b0;
    has_dn = 1'b0;
    up_idx = '0;
    dn_idx = '0;
    // Descending scan leaves the lowest index above; ascending leaves the highest below.
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && i > int'(cur_idx)) begin
        has_up = 1'b1;
        up_idx = IW'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && i < int'(cur_idx)) begin
        has_dn = 1'b1;
        dn_idx = IW'(i);
      end
  end

  always_comb begin
    hit_here   = pending[cur_idx];
    next_valid = has_up || has_dn;
    next_dir   = dir_up;
    next_index = '0;
    if (dir_up) begin
      if (has_up) next_index = up_idx;
      else begin
        next_index = dn_idx;
        next_dir   = 1'b0;
      end
    end else begin
      if (has_dn) next_index = dn_idx;
      else begin
        next_index = up_idx;
        next_dir   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pes_elevator_scheduler.sv
// Latches floor calls, picks targets by SCAN, dispatches one at a time and runs the door dwell.
module pes_elevator_scheduler import pes_elevator_pkg::*; #(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [NUM_FLOORS-1:0] current_floor,
  input  logic                  move_done,
  input  logic                  over_weight,
  output logic [NUM_FLOORS-1:0] target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  weight_hold,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault
);
  localparam int            IW       = $clog2(NUM_FLOORS);
  localparam int            CW       = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES - 1);

  state_e                  state, state_nxt;
  logic [NUM_FLOORS-1:0]   clr, target_nxt;
  logic                    dir_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    cur_ok;
  logic [IW-1:0]           cur_idx, next_index;
  logic                    hit_here, next_valid, next_dir;

  assign cur_ok  = is_onehot(MAX_FLOORS'(current_floor));
  assign cur_idx = IW'(onehot_to_index(MAX_FLOORS'(current_floor)));

  pes_scan_select #(.NUM_FLOORS(NUM_FLOORS), .IW(IW)) u_scan (
    .pending    (pending),
    .cur_idx    (cur_idx),
    .dir_up     (dir_up),
    .hit_here   (hit_here),
    .next_index (next_index),
    .next_valid (next_valid),
    .next_dir   (next_dir)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr        = '0;
    target_nxt = target_floor;
    dir_nxt    = dir_up;
    cnt_nxt    = cnt;
    case (state)
      IDLE: if (pending != '0 && cur_ok) state_nxt = SELECT;
      SELECT: begin
        if (hit_here) begin
          clr       = current_floor;
          cnt_nxt   = CNT_LOAD;
          state_nxt = DOOR;
        end else if (next_valid) begin
          target_nxt = NUM_FLOORS'(1) << next_index;
          dir_nxt    = next_dir;
          state_nxt  = DISPATCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      DISPATCH: if (move_done) begin
        clr       = target_floor;
        cnt_nxt   = CNT_LOAD;
        state_nxt = DOOR;
      end
      DOOR: begin
        if (over_weight)     cnt_nxt = CNT_LOAD;
        else if (cnt == '0)  state_nxt = IDLE;
        else                 cnt_nxt = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A bad floor reading now or last cycle parks the FSM; nothing is served or retargeted.
    if (fault || !cur_ok) begin
      state_nxt  = IDLE;
      clr        = '0;
      target_nxt = target_floor;
      dir_nxt    = dir_up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      target_floor <= '0;
      dir_up       <= 1'b1;
      cnt          <= '0;
      fault        <= 1'b0;
    end else begin
      pending      <= (pending | call_req) & ~clr;
      target_floor <= target_nxt;
      dir_up       <= dir_nxt;
      cnt          <= cnt_nxt;
      fault        <= !cur_ok;
    end
  end

  assign target_valid = (state == DISPATCH);
  assign door_open    = (state == DOOR);
  assign weight_hold  = door_open && over_weight;
endmodule

// File: tb/tb_pes_elevator_scheduler.sv
// Directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_pes_elevator_scheduler;
  localparam int NF = 8;
  localparam int DC = 4;
  localparam int P_IDLE = 0, P_SEL = 1, P_DISP = 2, P_DOOR = 3;

  logic          clk, reset, move_done, over_weight;
  logic [NF-1:0] call_req, current_floor;
  logic [NF-1:0] target_floor, pending;
  logic          target_valid, dir_up, door_open, weight_hold, fault;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  // model state
  int            m_phase;
  logic [NF-1:0] m_pend, m_tgt;
  bit            m_dir, m_fault;
  int            m_left;

  pes_elevator_scheduler #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_req      (call_req),
    .current_floor (current_floor),
    .move_done     (move_done),
    .over_weight   (over_weight),
    .target_floor  (target_floor),
    .target_valid  (target_valid),
    .dir_up        (dir_up),
    .door_open     (door_open),
    .weight_hold   (weight_hold),
    .pending       (pending),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NF-1:0] v);
    int r;
    r = -1;
    for (int f = 0; f < NF; f++) if (v[f]) r = f;
    return r;
  endfunction

  // Closest pending floor strictly beyond c in the given direction, -1 if none.
  function automatic int nearest(input logic [NF-1:0] p, input int c, input bit up);
    int best;
    best = -1;
    for (int f = 0; f < NF; f++)
      if (p[f]) begin
        if (up && f > c && (best < 0 || f < best)) best = f;
        if (!up && f < c && (best < 0 || f > best)) best = f;
      end
    return best;
  endfunction

  always @(posedge clk) begin
    logic [NF-1:0] served;
    int c, nxt;
    bit ok;
    served = '0;
    if (reset) begin
      m_phase = P_IDLE; m_pend = '0; m_tgt = '0; m_dir = 1; m_fault = 0; m_left = 0;
    end else begin
      ok = ($countones(current_floor) == 1);
      c  = idx_of(current_floor);
      if (!ok || m_fault) m_phase = P_IDLE;
      else case (m_phase)
        P_IDLE: if (m_pend != '0) m_phase = P_SEL;
        P_SEL: begin
          if (m_pend[c]) begin
            served = current_floor; m_phase = P_DOOR; m_left = DC;
          end else begin
            nxt = nearest(m_pend, c, m_dir);
            if (nxt < 0) begin
              nxt = nearest(m_pend, c, !m_dir);
              if (nxt >= 0) m_dir = !m_dir;
            end
            if (nxt >= 0) begin
              m_tgt = '0; m_tgt[nxt] = 1'b1; m_phase = P_DISP;
            end else m_phase = P_IDLE;
          end
        end
        P_DISP: if (move_done) begin
          served = m_tgt; m_phase = P_DOOR; m_left = DC;
        end
        default: begin
          if (over_weight)      m_left = DC;
          else if (m_left == 1) m_phase = P_IDLE;
          else                  m_left--;
        end
      endcase
      m_pend  = (m_pend | call_req) & ~served;
      m_fault = !ok;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("pending",      pending,      m_pend);
    chk("target_valid", target_valid, m_phase == P_DISP);
    chk("door_open",    door_open,    m_phase == P_DOOR);
    chk("dir_up",       dir_up,       m_dir);
    chk("fault",        fault,        m_fault);
    chk("weight_hold",  weight_hold,  (m_phase == P_DOOR) && over_weight);
    if (m_phase == P_DISP) chk("target_floor", target_floor, m_tgt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_call(input logic [NF-1:0] v);
    call_req = v;
    tick();
    call_req = '0;
  endtask

  task automatic wait_tv(input string name);
    int n;
    n = 0;
    while (!target_valid && n < 20) begin tick(); n++; end
    chk(name, n >= 20, 0);
  endtask

  task automatic count_door(input string name);
    int n;
    n = 0;
    while (door_open && n < 20) begin n++; tick(); end
    chk(name, n, DC);
  endtask

  // Plays the core: arrive at whatever is requested, then wait out the door.
  task automatic serve(output int fl, output bit d);
    int n;
    n = 0;
    while (!target_valid && !door_open && n < 20) begin tick(); n++; end
    chk("serve_timeout", n >= 20, 0);
    d  = dir_up;
    fl = idx_of(current_floor);
    if (target_valid) begin
      fl = idx_of(target_floor);
      tick();
      current_floor = target_floor;
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
    end
    n = 0;
    while (door_open && n < 20) begin tick(); n++; end
    chk("serve_door_close", n >= 20, 0);
  endtask

  initial begin
    int fl, n;
    bit d, saw_tv;
    logic [NF-1:0] cur_good;
    reset = 1; call_req = 8'hFF; current_floor = 8'h80; move_done = 0; over_weight = 0;

    // model pinned by hand-computed SCAN picks
    chk("model_up_5",   nearest(8'b1010_0010, 3, 1), 5);
    chk("model_dn_1",   nearest(8'b1010_0010, 3, 0), 1);
    chk("model_none",   nearest(8'h01, 0, 0), 32'hFFFF_FFFF);

    // reset with calls held
    tick(); chk_en = 1; tick();
    reset = 0; call_req = '0;
    chk("rst_pending", pending, 0);
    chk("rst_tv", target_valid, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_door", door_open, 0);

    // single call from the top floor
    pulse_call(8'h01); tick(); tick();
    chk("single_tv", target_valid, 1);
    chk("single_tf", target_floor, 8'h01);
    chk("single_dir", dir_up, 0);
    chk("model_single_tgt", m_tgt, 8'h01);
    current_floor = 8'h01; move_done = 1; tick(); move_done = 0;
    chk("single_pending", pending, 0);
    chk("single_door", door_open, 1);
    count_door("single_door_len");

    // SCAN order from floor 3 heading up
    current_floor = 8'h01;
    pulse_call(8'h08); serve(fl, d);
    chk("climb_fl", fl, 3); chk("climb_dir", d, 1);
    pulse_call(8'b1010_0010);
    serve(fl, d); chk("scan1_fl", fl, 5); chk("scan1_dir", d, 1);
    serve(fl, d); chk("scan2_fl", fl, 7); chk("scan2_dir", d, 1);
    serve(fl, d); chk("scan3_fl", fl, 1); chk("scan3_dir", d, 0);

    // call at the current floor: no motion
    current_floor = 8'h04;
    pulse_call(8'h04);
    saw_tv = 0; n = 0;
    while (!door_open && n < 8) begin if (target_valid) saw_tv = 1; tick(); n++; end
    chk("here_no_tv", saw_tv, 0);
    chk("here_door", door_open, 1);
    chk("here_pending", pending[2], 0);
    count_door("here_door_len");

    // overweight extends the dwell
    pulse_call(8'h10); wait_tv("ow_wait_tv");
    tick(); current_floor = 8'h10; move_done = 1; tick(); move_done = 0;
    for (int i = 0; i < 6; i++) begin
      over_weight = 1; #1;
      chk("ow_hold", {door_open, weight_hold}, 2'b11);
      tick();
    end
    over_weight = 0; #1;
    chk("ow_release_wh", weight_hold, 0);
    count_door("ow_door_len");

    // fault during dispatch
    pulse_call(8'h01); wait_tv("flt_wait_tv");
    current_floor = 8'h03; tick();
    chk("flt_fault", fault, 1);
    chk("flt_tv", target_valid, 0);
    current_floor = 8'h10;
    serve(fl, d); chk("flt_resume_fl", fl, 0);

    // reset while the door is open
    pulse_call(8'h22); wait_tv("rd_wait_tv");
    current_floor = target_floor; move_done = 1; tick(); move_done = 0;
    chk("rd_in_door", door_open, 1);
    reset = 1; call_req = 8'h40; tick();
    chk("rd_door", door_open, 0);
    chk("rd_pending", pending, 0);
    reset = 0; call_req = '0;

    // randomized traffic
    cur_good = current_floor;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset       = ($urandom_range(0, 199) == 0);
      call_req    = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      over_weight = ($urandom_range(0, 3) == 0);
      move_done   = 0;
      if (m_phase == P_DISP && $urandom_range(0, 2) == 0) begin
        cur_good  = m_tgt;
        move_done = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        move_done = 1;
      end
      current_floor = cur_good;
      if ($urandom_range(0, 49) == 0) current_floor = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h81;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pes_elevator_scheduler.md
Name: pes_elevator_scheduler

Overview:
- Request scheduler sitting in front of the pes_elevator core.
- Latches floor-call buttons into a pending set and picks the next target with a SCAN (continue-in-direction) policy.
- Drives a one-hot target floor to the core and waits for its completion signal.
- Then runs a door-dwell timer, extended while overweight, before serving the next call.

Parameters:
- NUM_FLOORS, 8, number of floors; width of all one-hot floor vectors.
- DOOR_CYCLES, 4, clock cycles the door stays open after arrival; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- call_req  input  NUM_FLOORS  call buttons, bit i = floor i; pulse or level, OR-latched.
- current_floor  input  NUM_FLOORS  one-hot current floor from the core (out_current_floor).
- move_done  input  1  core "complete"; arrival at target_floor.
- over_weight  input  1  cabin overweight sensor.
- target_floor  output  NUM_FLOORS  one-hot requested floor to the core (request_floor).
- target_valid  output  1  target_floor is a live request.
- dir_up  output  1  scan direction, 1 = up.
- door_open  output  1  door open command.
- weight_hold  output  1  dwell is being extended due to over_weight.
- pending  output  NUM_FLOORS  outstanding calls.
- fault  output  1  current_floor is not one-hot (zero or multi-hot).

Behaviour:
- Reset (sync, reset=1 at a clk edge) values:
  - state=IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1, door_open=0, weight_hold=0, fault=0, dwell counter=0.
  - Reset mid-operation abandons any target and discards all pending calls.
- Pending register:
  - Updated every cycle as pending <= (pending | call_req) & ~clr.
  - clr is the one-hot floor being served, asserted only in the cycle of DOOR entry.
  - A call on the served floor in that same cycle is dropped (clear wins).
- fault:
  - Registered, equals "current_floor not one-hot" from the previous cycle.
  - While fault=1 the FSM is forced to IDLE and target_valid=0; pending keeps latching.
- State IDLE:
  - Outputs: target_valid=0, door_open=0.
  - If pending!=0 and current_floor is valid, go to SELECT next cycle.
- State SELECT (1 cycle): let c = index of current_floor. Checks in order:
  - (a) pending bit c set: clr=bit c, go to DOOR with no motion.
  - (b) dir_up=1 and any pending above c: target = lowest pending index > c, go to DISPATCH.
  - (c) dir_up=1, none above, some below: target = highest pending index < c, dir_up<=0, go to DISPATCH.
  - (d) Mirror of (b)/(c) for dir_up=0: nearest below first, else nearest above with dir_up<=1.
  - target_floor is registered on entry to DISPATCH.
- State DISPATCH:
  - target_valid=1 and target_floor held stable; no preemption by new calls.
  - On move_done=1: clr=target_floor, go to DOOR.
  - move_done is ignored in all other states.
- State DOOR:
  - On entry: door_open=1, target_valid=0, counter=DOOR_CYCLES-1.
  - Each cycle: if over_weight=1, weight_hold=1 and counter reloads to DOOR_CYCLES-1; otherwise counter decrements.
  - Exit: when counter=0 and over_weight=0, go to IDLE next cycle with door_open=0.
  - Door stays open for exactly DOOR_CYCLES cycles when over_weight=0.
- Latency: call registered to target_valid high takes 3 cycles when idle (latch, IDLE->SELECT, SELECT->DISPATCH).
- Only one target is in flight at a time.

Decomposition:
- Package pes_elevator_pkg holds:
  - State enum (IDLE, SELECT, DISPATCH, DOOR).
  - Default NUM_FLOORS and DOOR_CYCLES constants.
  - Functions is_onehot and onehot_to_index.
- One natural sub-module: pes_scan_select.
  - Combinational; inputs pending, current index, dir_up.
  - Outputs hit_here, next_index, next_valid, next_dir.
  - Keeps the priority-search logic separate from the FSM.

Test Plan:
- Reset: assert reset 2 cycles with call_req=8'hFF -> pending=0, target_valid=0, dir_up=1, door_open=0 after release.
- Single call: current_floor=8'h80, call_req=8'h01 pulse -> within 3 cycles target_floor=8'h01, target_valid=1, dir_up=0; move_done pulse -> pending=0, door_open=1 for exactly 4 cycles.
- SCAN order: current_floor=8'h08 (floor 3), dir_up=1, pending=8'b1010_0010 -> service order floors 5, 7, then 1; dir_up flips to 0 only before floor 1.
- Call at current floor: current_floor=8'h04, call_req=8'h04 -> no target_valid, door_open=1 for 4 cycles, pending bit 2 cleared.
- Over-weight: during DOOR, hold over_weight=1 for 6 cycles -> weight_hold=1, door_open stays 1 throughout; closes 4 cycles after over_weight drops.
- Fault/reset mid-op: in DISPATCH drive current_floor=8'h03 -> next cycle fault=1, target_valid=0, IDLE. Separately, reset in DOOR -> door_open=0 and pending=0 next cycle.
